riscv_irq_gateway: RTL and testbench
====================================

Name: riscv_irq_gateway

Overview:
- Conditions raw peripheral interrupt lines before the core interrupt controller (INTCTRL) sees them.
- Per line: synchronises the asynchronous line, then applies edge or level detection.
- Per line: keeps a pending bit and an in-service bit.
- Arbitrates pending lines by fixed priority and presents one request at a time to INTCTRL over a valid/ready claim handshake.
- A completion port releases in-service lines.

Parameters:
- NUMINT, riscv_intc_pkg::NUMINT (4): number of interrupt lines.
- SYNC_STAGES, 2: synchroniser flops per line; legal values are 2 or more.
- EDGE_MASK, '1 (NUMINT bits): bit i = 1 makes line i rising-edge triggered; bit i = 0 makes it level (active-high).

Ports:
- clk_i  in  1  core clock.
- rst_n_i  in  1  synchronous reset, active-low.
- irq_src_i  in  NUMINT  asynchronous interrupt lines from peripherals.
- irq_en_i  in  NUMINT  per-line enable from the CSR/INTCTRL configuration.
- irq_valid_o  out  1  a request is presented to INTCTRL.
- irq_id_o  out  IRQ_ID_W  index of the presented line.
- irq_ready_i  in  1  INTCTRL claims the presented request.
- cmpl_valid_i  in  1  INTCTRL signals that servicing has completed.
- cmpl_id_i  in  IRQ_ID_W  line being completed.
- pending_o  out  NUMINT  pending bits, exposed for CSR read (mip-style).

Behaviour:
- Reset: on rst_n_i=0 at a clk_i edge, all synchroniser flops, edge-history flops, pending, in-service, irq_valid_o, irq_id_o and pending_o go to 0. Reset mid-handshake drops any outstanding request; no completion is expected after reset.
- Sync: s[i] is irq_src_i[i] delayed by SYNC_STAGES flops.
- Edge detect: prev[i] holds s[i] from the previous cycle.
- Edge-line pending set: when s[i] & ~prev[i].
- Edge-line pending clear: only when line i is claimed.
- Edge line asserting while in service: pending[i] sets and is queued. Depth is 1; further edges merge.
- Edge arriving in the same cycle as the claim of the same line: the set wins, so pending stays 1.
- Level lines: pending[i] = s[i], registered each cycle, and forced to 0 while in_service[i]=1.
- Latency, edge lines: a clean rising edge on irq_src_i appears on pending_o SYNC_STAGES+1 cycles later. With output idle, irq_valid_o rises one cycle after that, i.e. 4 cycles for SYNC_STAGES=2.
- Candidate set: cand = pending & irq_en_i & ~in_service. The winner is the lowest set index.
- Output register load: loads when irq_valid_o=0 or (irq_valid_o & irq_ready_i).
  - On load: irq_valid_o = |cand'; irq_id_o = winner of cand'.
  - cand' equals cand, except the line being claimed in this cycle is excluded. This allows back-to-back requests from different lines with no bubble.
- Stability: while irq_valid_o=1 and irq_ready_i=0, irq_valid_o and irq_id_o hold. There is no retraction, even if irq_en_i or the level source deasserts. INTCTRL treats any resulting spurious claim as its own concern.
- Claim (irq_valid_o & irq_ready_i):
  - in_service[irq_id_o] is set next cycle.
  - The pending bit of an edge line is cleared next cycle, unless a new edge arrives in that same cycle.
- irq_ready_i while irq_valid_o=0: ignored.
- Completion: cmpl_valid_i clears in_service[cmpl_id_i] next cycle.
- Completion for a line that is not in service: ignored.
- Completion ids ≥ NUMINT: ignored.
- Completion and claim of different lines in the same cycle: both take effect.
- A completed line whose pending bit is set becomes a candidate in the cycle after in_service clears.
- Per-line state model:
  - IDLE → PEND on set.
  - PEND → PRESENTED on output load.
  - PRESENTED → INSVC on claim; becomes INSVC+PEND if a re-edge occurred.
  - INSVC → IDLE, or INSVC+PEND → PEND, on completion.

Decomposition:
- Add to riscv_intc_pkg:
  - localparam IRQ_ID_W = (NUMINT>1) ? $clog2(NUMINT) : 1;
  - typedef logic [IRQ_ID_W-1:0] irq_id_t;
  - typedef logic [NUMINT-1:0] irq_vec_t.
- Sub-module riscv_irq_sync: parameterised width and SYNC_STAGES, one flop chain per bit, synchronous active-low reset. It is instantiated once with width NUMINT.
- The priority encoder stays inline as a function.

Test Plan:
- Edge latency (NUMINT=4, SYNC_STAGES=2, EDGE_MASK=4'hF, en=4'hF, ready=0): pulse irq_src_i[2] for 3 cycles → pending_o=4'b0100 after 3 cycles; irq_valid_o=1 with id=2 after 4 cycles; held stable for 10 cycles with ready=0.
- Priority and back-to-back: lines 1 and 3 pending, ready=1 continuously → id=1 for one cycle, then id=3 the next cycle, then valid=0; in_service=4'b1010.
- Re-edge during service: claim line 0, pulse line 0 again → pending_o[0]=1 but no request; cmpl_valid_i with id=0 → irq_valid_o=1, id=0 two cycles later.
- Level line (EDGE_MASK=4'b1110, line 0 level): hold src[0]=1 → claim; in service, no new request; complete while src[0]=1 → re-requested; src[0]=0 before completion → no re-request.
- Enable masking and no-retract: pending 4'b0100 with en=4'b1011 → valid stays 0; set en[2] → valid with id=2; drop en[2] while ready=0 → valid/id held.
- Reset mid-operation: with valid=1 and two lines in service, assert rst_n_i=0 for 1 cycle → all outputs 0 next edge; ignored completion afterward causes no change.

Source files
------------

// File: rtl/riscv_intc_pkg.sv
// Shared sizing and types for the interrupt controller front end.
package riscv_intc_pkg;

  localparam int NUMINT   = 4;
  localparam int IRQ_ID_W = (NUMINT > 1) ? $clog2(NUMINT) : 1;

  typedef logic [IRQ_ID_W-1:0] irq_id_t;
  typedef logic [NUMINT-1:0]   irq_vec_t;

endpackage

// File: rtl/riscv_irq_sync.sv
// Multi-flop synchroniser: one independent flop chain per bit.
module riscv_irq_sync #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] synced
);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [SYNC_STAGES-1:0] chain_reg;

      // Shift the raw line through SYNC_STAGES flops; oldest stage is the output.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          chain_reg <= '0;
        end else begin
          chain_reg <= {chain_reg[SYNC_STAGES-2:0], raw[gi]};
        end
      end

      assign synced[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/riscv_irq_gateway.sv
// Interrupt gateway: synchronise, detect, track pending/in-service per line,
// and present the lowest-index candidate to INTCTRL over valid/ready.
module riscv_irq_gateway #(
  parameter int                NUMINT      = riscv_intc_pkg::NUMINT,
  parameter int                SYNC_STAGES = 2,
  parameter logic [NUMINT-1:0] EDGE_MASK   = '1,
  localparam int               ID_W        = (NUMINT > 1) ? $clog2(NUMINT) : 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [NUMINT-1:0] irq_src_i,
  input  logic [NUMINT-1:0] irq_en_i,
  output logic              irq_valid_o,
  output logic [ID_W-1:0]   irq_id_o,
  input  logic              irq_ready_i,
  input  logic              cmpl_valid_i,
  input  logic [ID_W-1:0]   cmpl_id_i,
  output logic [NUMINT-1:0] pending_o
);

  logic [NUMINT-1:0] sync_s;
  logic [NUMINT-1:0] prev_reg;
  logic [NUMINT-1:0] pending_reg, pending_next;
  logic [NUMINT-1:0] in_service_reg, in_service_next;
  logic [NUMINT-1:0] claim_vec, cmpl_vec, cand, cand_load;
  logic              valid_reg, valid_next;
  logic [ID_W-1:0]   id_reg, id_next;
  logic              claim, load;

  // Lowest set index wins; returns 0 for an empty vector.
  function automatic logic [ID_W-1:0] lowest_index(input logic [NUMINT-1:0] vec);
    lowest_index = '0;
    for (int i = NUMINT - 1; i >= 0; i--) begin
      if (vec[i]) lowest_index = ID_W'(i);
    end
  endfunction

  riscv_irq_sync #(
    .WIDTH       (NUMINT),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .raw    (irq_src_i),
    .synced (sync_s)
  );

  assign claim = valid_reg & irq_ready_i;
  assign load  = ~valid_reg | claim;

  generate
    for (genvar gi = 0; gi < NUMINT; gi++) begin : g_line
      // Ids >= NUMINT never match any line, so they fall out naturally.
      assign claim_vec[gi] = claim && (id_reg == ID_W'(gi));
      assign cmpl_vec[gi]  = cmpl_valid_i && (cmpl_id_i == ID_W'(gi));
      // Edge lines: a new rising edge beats a simultaneous claim clear.
      // Level lines: follow the synced source, masked while in service.
      assign pending_next[gi] = EDGE_MASK[gi]
          ? ((sync_s[gi] & ~prev_reg[gi]) | (pending_reg[gi] & ~claim_vec[gi]))
          : (sync_s[gi] & ~in_service_reg[gi]);
    end
  endgenerate

  // A claim in the same cycle as a completion of that line leaves it in service,
  // since the completion targets a line that was not yet in service.
  assign in_service_next = (in_service_reg & ~cmpl_vec) | claim_vec;

  assign cand      = pending_reg & irq_en_i & ~in_service_reg;
  assign cand_load = cand & ~claim_vec;

  // Output register reloads when idle or on claim; otherwise it holds (no retraction).
  always_comb begin
    valid_next = valid_reg;
    id_next    = id_reg;
    if (load) begin
      valid_next = |cand_load;
      id_next    = lowest_index(cand_load);
    end
  end

  // Per-line state and the presented request.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      prev_reg       <= '0;
      pending_reg    <= '0;
      in_service_reg <= '0;
      valid_reg      <= 1'b0;
      id_reg         <= '0;
    end else begin
      prev_reg       <= sync_s;
      pending_reg    <= pending_next;
      in_service_reg <= in_service_next;
      valid_reg      <= valid_next;
      id_reg         <= id_next;
    end
  end

  assign irq_valid_o = valid_reg;
  assign irq_id_o    = id_reg;
  assign pending_o   = pending_reg;

endmodule

// File: tb/tb_riscv_irq_gateway.sv
// Directed bench for riscv_irq_gateway. Line 0 is level-triggered, lines 1-3
// edge-triggered. Claimed ids are checked by a scoreboard monitor.
module tb_riscv_irq_gateway;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] src, en;
  logic       ready, cmpl_valid;
  logic [1:0] cmpl_id;
  logic       valid;
  logic [1:0] id;
  logic [3:0] pending;

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  riscv_irq_gateway #(
    .NUMINT      (4),
    .SYNC_STAGES (2),
    .EDGE_MASK   (4'b1110)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .irq_src_i    (src),
    .irq_en_i     (en),
    .irq_valid_o  (valid),
    .irq_id_o     (id),
    .irq_ready_i  (ready),
    .cmpl_valid_i (cmpl_valid),
    .cmpl_id_i    (cmpl_id),
    .pending_o    (pending)
  );

  // Scoreboard monitor: every handshake must match the next expected id.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && valid && ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL claim_unexpected: got id=%0d, expected no claim", id);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (id !== e) begin
          bad++;
          $display("FAIL claim_id: got id=%0d, expected id=%0d", id, e);
        end else begin
          $display("claim id=%0d ok", id);
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  // Pulse edge lines for 3 cycles; returns 4 cycles after the rising edge.
  task automatic fire(input logic [3:0] mask);
    src = src | mask;
    tick(3);
    src = src & ~mask;
    tick(1);
  endtask

  task automatic expect_claim(input logic [1:0] e);
    exp_q.push_back(e);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
  endtask

  task automatic complete(input logic [1:0] c);
    cmpl_valid = 1'b1;
    cmpl_id    = c;
    tick(1);
    cmpl_valid = 1'b0;
    cmpl_id    = 2'd0;
  endtask

  task automatic wait_valid(input string name, input int max_cycles);
    int n;
    n = 0;
    while (!valid && n < max_cycles) begin
      tick(1);
      n++;
    end
    check(name, int'(valid), 1);
  endtask

  initial begin
    rst_n = 1'b0; src = '0; en = 4'hF; ready = 1'b0;
    cmpl_valid = 1'b0; cmpl_id = 2'd0;
    tick(3);
    check("rst_valid", int'(valid), 0);
    check("rst_id", int'(id), 0);
    check("rst_pending", int'(pending), 0);
    rst_n = 1'b1;
    tick(2);

    // Edge latency on line 2, then hold with ready low.
    src[2] = 1'b1;
    tick(2);
    check("lat_pending_early", int'(pending), 0);
    tick(1);
    src[2] = 1'b0;
    check("lat_pending", int'(pending), 4);
    check("lat_valid_early", int'(valid), 0);
    tick(1);
    check("lat_valid", int'(valid), 1);
    check("lat_id", int'(id), 2);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check("hold_valid_id", int'({valid, id}), 6);
    end
    expect_claim(2'd2);
    check("after_claim_valid", int'(valid), 0);
    check("after_claim_pending", int'(pending), 0);
    complete(2'd2);
    tick(2);
    check("after_cmpl_valid", int'(valid), 0);
    tick(2);

    // Priority and back-to-back claims of lines 1 and 3.
    fire(4'b1010);
    check("prio_pending", int'(pending), 10);
    check("prio_first_id", int'(id), 1);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    ready = 1'b1;
    tick(1);
    check("b2b_valid", int'(valid), 1);
    check("b2b_id", int'(id), 3);
    tick(1);
    ready = 1'b0;
    check("b2b_drain_valid", int'(valid), 0);
    check("b2b_drain_pending", int'(pending), 0);
    complete(2'd1);
    complete(2'd3);
    tick(2);

    // Re-edge on line 1 while it is in service.
    fire(4'b0010);
    check("reedge_first_id", int'({valid, id}), 5);
    expect_claim(2'd1);
    src[1] = 1'b1;
    tick(3);
    src[1] = 1'b0;
    check("reedge_pending", int'(pending), 2);
    check("reedge_no_req", int'(valid), 0);
    tick(2);
    check("reedge_still_no_req", int'(valid), 0);
    complete(2'd1);
    check("reedge_cmpl_wait", int'(valid), 0);
    tick(1);
    check("reedge_rerequest", int'({valid, id}), 5);
    expect_claim(2'd1);
    complete(2'd1);
    tick(2);

    // Level line 0.
    src[0] = 1'b1;
    tick(4);
    check("level_req", int'({valid, id}), 4);
    expect_claim(2'd0);
    tick(2);
    check("level_insvc_pending", int'(pending), 0);
    check("level_insvc_valid", int'(valid), 0);
    tick(1);
    check("level_insvc_valid2", int'(valid), 0);
    complete(2'd0);
    wait_valid("level_rerequest", 8);
    check("level_rerequest_id", int'(id), 0);
    expect_claim(2'd0);
    src[0] = 1'b0;
    tick(4);
    complete(2'd0);
    tick(6);
    check("level_no_rerequest", int'(valid), 0);
    check("level_idle_pending", int'(pending), 0);

    // Enable masking and no retraction.
    en = 4'b1011;
    fire(4'b0100);
    check("mask_pending", int'(pending), 4);
    check("mask_valid", int'(valid), 0);
    tick(2);
    check("mask_valid2", int'(valid), 0);
    en = 4'hF;
    tick(1);
    check("unmask_req", int'({valid, id}), 6);
    en = 4'b1011;
    tick(1);
    check("noretract_1", int'({valid, id}), 6);
    tick(1);
    check("noretract_2", int'({valid, id}), 6);
    en = 4'hF;
    expect_claim(2'd2);
    complete(2'd2);
    tick(3);

    // Reset with a request presented and two lines in service.
    fire(4'b1110);
    check("rstmid_first", int'({valid, id}), 5);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    ready = 1'b1;
    tick(2);
    ready = 1'b0;
    check("rstmid_presented", int'({valid, id}), 7);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("rstmid_valid", int'(valid), 0);
    check("rstmid_id", int'(id), 0);
    check("rstmid_pending", int'(pending), 0);
    complete(2'd1);
    tick(4);
    check("rstmid_quiet_valid", int'(valid), 0);
    check("rstmid_quiet_pending", int'(pending), 0);
    fire(4'b0010);
    check("post_rst_req", int'({valid, id}), 5);
    expect_claim(2'd1);
    complete(2'd1);
    tick(2);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
